bf_query_sched: RTL and testbench

Batch scheduler in front of the Bellman-Ford engine. It walks the source/destination query list in Input Memory and launches one engine run per pair. Each run ends on the engine's completion or on a watchdog timeout. The block owns the Input Memory read port while a batch is active, and it reports batch status to the host.

---
 rtl/bf_pkg.sv | 32 +++
 rtl/bf_watchdog.sv | 28 ++
 rtl/bf_query_sched.sv | 187 ++++++++++++++++++
 tb/tb_bf_query_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the Bellman-Ford batch query scheduler.
// Holds the FSM state encoding, error codes and the query-list terminator.
package bf_pkg;

    localparam int BF_AW = 13;

    localparam logic [7:0] TERM = 8'hFF;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_ID   = 2'd1;
    localparam logic [1:0] ERR_UNPAIRED = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_S,
        S_WAIT_S,
        S_LATCH_S,
        S_FETCH_D,
        S_WAIT_D,
        S_LATCH_D,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    // Node ids are 1..nodes; zero is never a node.
    function automatic logic id_valid(input logic [7:0] id, input logic [7:0] nodes);
        return (id != 8'd0) && (id <= nodes);
    endfunction

endpackage

// File: rtl/bf_watchdog.sv
// Run-length watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count of enabled cycles reaches TIMEOUT.
module bf_watchdog #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // cnt_q holds the number of earlier enabled cycles, so the TIMEOUT-th one expires.
    assign expire = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expire) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/bf_query_sched.sv
// Batch scheduler: walks the S/D query list in Input Memory, launches one
// engine run per pair and reports batch status, count and first error.
module bf_query_sched
    import bf_pkg::*;
#(
    parameter int          AW      = BF_AW,
    parameter int unsigned TIMEOUT = 16'd50000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          host_start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    num_nodes,
    output logic [AW-1:0] IMAR,
    input  logic [7:0]    IMDR,
    output logic          bf_start,
    output logic [7:0]    bf_src,
    output logic [7:0]    bf_dst,
    input  logic          bf_done,
    output logic          bf_abort,
    output logic          busy,
    output logic          batch_done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    query_cnt,
    output state_t        state_dbg_o
);

    // Handshake: host_start is honoured only in IDLE; bf_done only in RUN;
    // bf_start and bf_abort are single-cycle pulses with no acknowledge.

    state_t        state_q, state_d;
    logic [AW-1:0] imar_q, imar_d;
    logic [7:0]    nodes_q, nodes_d;
    logic [7:0]    src_q, src_d;
    logic [7:0]    dst_q, dst_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          abort_q, abort_d;
    logic [7:0]    imdr_q;

    logic is_term, id_ok, at_top, adv_ok;
    logic err_hit;
    logic [1:0] err_val;
    logic wd_clear, wd_enable, wd_expire;

    assign is_term = (imdr_q == TERM);
    assign id_ok   = id_valid(imdr_q, nodes_q);
    assign at_top  = (imar_q == {AW{1'b1}});
    assign adv_ok  = !is_term && id_ok && !at_top;

    bf_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (host_start) state_d = S_FETCH_S;
            S_FETCH_S: state_d = S_WAIT_S;
            S_WAIT_S:  state_d = S_LATCH_S;
            S_LATCH_S: state_d = adv_ok ? S_FETCH_D : S_DONE;
            S_FETCH_D: state_d = S_WAIT_D;
            S_WAIT_D:  state_d = S_LATCH_D;
            S_LATCH_D: state_d = adv_ok ? S_LAUNCH : S_DONE;
            S_LAUNCH:  state_d = S_RUN;
            S_RUN: begin
                if (bf_done)        state_d = S_FETCH_S;
                else if (wd_expire) state_d = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bf_start   = (state_q == S_LAUNCH);
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        batch_done = (state_q == S_DONE);
        wd_clear   = (state_q == S_LAUNCH);
        wd_enable  = (state_q == S_RUN);
    end

    always_comb begin
        imar_d  = imar_q;
        nodes_d = nodes_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        code_d  = code_q;
        abort_d = 1'b0;
        err_hit = 1'b0;
        err_val = ERR_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    imar_d  = base_addr;
                    nodes_d = num_nodes;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                end
            end
            S_LATCH_S: begin
                if (adv_ok) begin
                    src_d  = imdr_q;
                    imar_d = imar_q + AW'(1);
                end else if (!is_term) begin
                    err_hit = 1'b1;
                    err_val = id_ok ? ERR_TIMEOUT : ERR_BAD_ID;
                end
            end
            S_LATCH_D: begin
                if (adv_ok) begin
                    dst_d  = imdr_q;
                    imar_d = imar_q + AW'(1);
                end else begin
                    err_hit = 1'b1;
                    err_val = is_term ? ERR_UNPAIRED : (!id_ok ? ERR_BAD_ID : ERR_TIMEOUT);
                end
            end
            S_RUN: begin
                // Completion wins over a coincident expiry.
                if (bf_done) begin
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end else if (wd_expire) begin
                    abort_d = 1'b1;
                    err_hit = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
        if (err_hit && !err_q) begin
            err_d  = 1'b1;
            code_d = err_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            imar_q  <= '0;
            nodes_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            abort_q <= 1'b0;
            imdr_q  <= '0;
        end else begin
            imar_q  <= imar_d;
            nodes_q <= nodes_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
            abort_q <= abort_d;
            imdr_q  <= IMDR;
        end
    end

    assign IMAR        = imar_q;
    assign bf_src      = src_q;
    assign bf_dst      = dst_q;
    assign bf_abort    = abort_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign query_cnt   = cnt_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bf_query_sched.sv
// Bench for bf_query_sched: a per-query timing model predicts every output
// each cycle; an expected queue pins the launched (src,dst) pairs.
module tb_bf_query_sched;
    import bf_pkg::*;

    localparam int AW  = 13;
    localparam int TO  = 100;
    localparam int TLN = 8192;
    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          host_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    num_nodes = 8'd8;
    logic [AW-1:0] IMAR;
    logic [7:0]    IMDR;
    logic          bf_start;
    logic [7:0]    bf_src, bf_dst;
    logic          bf_done = 1'b0;
    logic          bf_abort, busy, batch_done, err;
    logic [1:0]    err_code;
    logic [7:0]    query_cnt;
    state_t        state_dbg;

    logic [7:0] mem [0:(1<<AW)-1];
    assign IMDR = mem[IMAR];

    bf_query_sched #(.AW(AW), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .host_start  (host_start),
        .base_addr   (base_addr),
        .num_nodes   (num_nodes),
        .IMAR        (IMAR),
        .IMDR        (IMDR),
        .bf_start    (bf_start),
        .bf_src      (bf_src),
        .bf_dst      (bf_dst),
        .bf_done     (bf_done),
        .bf_abort    (bf_abort),
        .busy        (busy),
        .batch_done  (batch_done),
        .err         (err),
        .err_code    (err_code),
        .query_cnt   (query_cnt),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- engine stand-in ----------------
    int   eng_lat = 0;
    int   done_at = -1;
    logic stray_done = 1'b0;
    always @(posedge clock) begin
        #2;
        if (reset) done_at = -1;
        bf_done = (done_at == cyc) || stray_done;
    end
    always @(negedge clock) begin
        if (!reset && bf_start && eng_lat > 0) done_at = cyc + eng_lat;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          busy;
        logic          start;
        logic          abort;
        logic          bdone;
        logic          err;
        logic [1:0]    code;
        logic [7:0]    cnt;
        logic [7:0]    src;
        logic [7:0]    dst;
        logic [AW-1:0] imar;
    } exp_t;

    exp_t tl [0:TLN-1];
    exp_t cur;
    int   ptr = 0;
    bit   m_fin;

    task automatic advance(input int upto);
        while (ptr < upto) begin
            if (ptr < TLN) tl[ptr] = cur;
            ptr++;
        end
    endtask

    task automatic m_err(input logic [1:0] c);
        if (!cur.err) begin
            cur.err  = 1'b1;
            cur.code = c;
        end
    endtask

    task automatic m_finish(input int c);
        advance(c);
        cur.busy  = 1'b0;
        cur.bdone = 1'b1;
        advance(c + 1);
        cur.bdone = 1'b0;
        cur.abort = 1'b0;
        m_fin     = 1'b1;
    endtask

    // Each query: byte decisions 3 and 6 cycles after its trigger, launch at 7;
    // a run ends on done (lat <= TO) or aborts after TO run cycles.
    task automatic plan(input int t0, input logic [AW-1:0] base, input logic [7:0] nn, input int lat);
        logic [AW-1:0] addr;
        logic [7:0] s, d;
        int t, s0;
        advance(t0 + 1);
        cur.busy = 1'b1; cur.err = 1'b0; cur.code = 2'd0; cur.cnt = 8'd0; cur.imar = base;
        addr = base; t = t0; m_fin = 1'b0;
        while (!m_fin) begin
            s = mem[addr];
            advance(t + 4);
            if (s == 8'hFF) m_finish(t + 4);
            else if (s == 8'd0 || s > nn) begin m_err(2'd1); m_finish(t + 4); end
            else if (addr == ADDR_MAX) begin m_err(2'd3); m_finish(t + 4); end
            else begin
                cur.src = s; addr = addr + 1'b1; cur.imar = addr;
                d = mem[addr];
                advance(t + 7);
                if (d == 8'hFF) begin m_err(2'd2); m_finish(t + 7); end
                else if (d == 8'd0 || d > nn) begin m_err(2'd1); m_finish(t + 7); end
                else if (addr == ADDR_MAX) begin m_err(2'd3); m_finish(t + 7); end
                else begin
                    cur.dst = d; addr = addr + 1'b1; cur.imar = addr;
                    s0 = t + 7;
                    cur.start = 1'b1; advance(s0 + 1); cur.start = 1'b0;
                    if (lat >= 1 && lat <= TO) begin
                        advance(s0 + lat + 1);
                        if (cur.cnt != 8'd255) cur.cnt = cur.cnt + 8'd1;
                        t = s0 + lat;
                    end else begin
                        advance(s0 + TO + 1);
                        m_err(2'd3);
                        cur.abort = 1'b1;
                        m_finish(s0 + TO + 1);
                    end
                end
            end
        end
    endtask

    task automatic model_reset(input int r);
        if (ptr > r + 1) ptr = r + 1;
        else advance(r + 1);
        cur = '0;
    endtask

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int abort_seen = 0;

    always @(negedge clock) begin : cmp
        exp_t e;
        if (chk_en) begin
            e = (cyc < ptr && cyc < TLN) ? tl[cyc] : cur;
            chk("busy", busy, e.busy);
            chk("bf_start", bf_start, e.start);
            chk("bf_abort", bf_abort, e.abort);
            chk("batch_done", batch_done, e.bdone);
            chk("err", err, e.err);
            chk("err_code", err_code, e.code);
            chk("query_cnt", query_cnt, e.cnt);
            chk("bf_src", bf_src, e.src);
            chk("bf_dst", bf_dst, e.dst);
            chk("IMAR", IMAR, e.imar);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (bf_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected cyc=%0d got=%0h want=none", cyc, {bf_src, bf_dst});
                end else begin
                    chk("start_pair", {bf_src, bf_dst}, exp_q.pop_front());
                end
            end
            if (bf_abort) abort_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_batch(input logic [AW-1:0] base, input logic [7:0] nn, input int lat,
                             input int budget, input int dup_at, input int stray_at);
        bit seen;
        seen = 1'b0;
        eng_lat = lat;
        @(posedge clock); #1;
        host_start = 1'b1; base_addr = base; num_nodes = nn;
        plan(cyc, base, nn, lat);
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clock); #1;
            host_start = (i == dup_at);
            if (i == dup_at) base_addr = '0;
            stray_done = (i == stray_at);
            @(negedge clock);
            seen = batch_done;
        end
        @(posedge clock); #1;
        host_start = 1'b0; stray_done = 1'b0;
        chk("batch_done_seen", seen, 1'b1);
    endtask

    task automatic load(input logic [AW-1:0] base, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        mem[base] = b0; mem[base + 1] = b1; mem[base + 2] = b2;
        mem[base + 3] = b3; mem[base + 4] = b4;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int a0;
        logic [AW-1:0] sb;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'h00;
        cur = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        ptr = cyc;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_state", state_dbg, S_IDLE);
        chk("rst_imar", IMAR, 0);
        chk("rst_busy", busy, 0);

        // Two pairs, stray done while fetching, host_start while busy.
        load(13'h10, 8'd3, 8'd7, 8'd5, 8'd2, 8'hFF);
        exp_q.push_back({8'd3, 8'd7});
        exp_q.push_back({8'd5, 8'd2});
        run_batch(13'h10, 8'd8, 20, 300, 30, 1);
        chk("t1_cnt", query_cnt, 8'd2);
        chk("t1_imar", IMAR, 13'h14);
        chk("t1_err", err, 1'b0);
        chk("t1_starts_left", exp_q.size(), 0);

        load(13'h40, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        run_batch(13'h40, 8'd8, 20, 100, -1, -1);
        chk("t2_cnt", query_cnt, 8'd0);
        chk("t2_err", err, 1'b0);

        load(13'h50, 8'd4, 8'hFF, 8'h00, 8'h00, 8'h00);
        run_batch(13'h50, 8'd8, 20, 100, -1, -1);
        chk("t3_err", err, 1'b1);
        chk("t3_code", err_code, 2'd2);
        chk("t3_imar", IMAR, 13'h51);

        load(13'h60, 8'd9, 8'd1, 8'h00, 8'h00, 8'h00);
        run_batch(13'h60, 8'd8, 20, 100, -1, -1);
        chk("t4_code", err_code, 2'd1);

        load(13'h68, 8'd2, 8'd0, 8'h00, 8'h00, 8'h00);
        run_batch(13'h68, 8'd8, 20, 100, -1, -1);
        chk("t4b_code", err_code, 2'd1);
        chk("t4b_src", bf_src, 8'd2);

        load(13'h70, 8'd6, 8'd6, 8'hFF, 8'h00, 8'h00);
        exp_q.push_back({8'd6, 8'd6});
        run_batch(13'h70, 8'd8, 5, 100, -1, -1);
        chk("t5_cnt", query_cnt, 8'd1);
        chk("t5_err", err, 1'b0);

        // Engine never completes: abort after TO run cycles.
        load(13'h80, 8'd1, 8'd2, 8'hFF, 8'h00, 8'h00);
        exp_q.push_back({8'd1, 8'd2});
        a0 = abort_seen;
        run_batch(13'h80, 8'd8, 0, 300, -1, -1);
        chk("t6_aborts", abort_seen - a0, 1);
        chk("t6_code", err_code, 2'd3);
        chk("t6_cnt", query_cnt, 8'd0);

        // Done coincides with expiry: counted, no abort.
        load(13'h90, 8'd1, 8'd2, 8'd3, 8'd4, 8'hFF);
        exp_q.push_back({8'd1, 8'd2});
        exp_q.push_back({8'd3, 8'd4});
        a0 = abort_seen;
        run_batch(13'h90, 8'd8, TO, 400, -1, -1);
        chk("t7_aborts", abort_seen - a0, 0);
        chk("t7_cnt", query_cnt, 8'd2);
        chk("t7_err", err, 1'b0);

        // Address would wrap on the destination byte.
        mem[13'h1FFE] = 8'd1;
        mem[13'h1FFF] = 8'd2;
        run_batch(13'h1FFE, 8'd8, 20, 100, -1, -1);
        chk("t8_code", err_code, 2'd3);
        chk("t8_imar", IMAR, 13'h1FFF);

        // 257 runs: counter saturates at 255.
        sb = 13'h200;
        for (int i = 0; i < 257; i++) begin
            mem[sb + 2 * i]     = 8'((i % 8) + 1);
            mem[sb + 2 * i + 1] = 8'(((i * 3) % 8) + 1);
            exp_q.push_back({8'((i % 8) + 1), 8'(((i * 3) % 8) + 1)});
        end
        mem[sb + 514] = 8'hFF;
        run_batch(sb, 8'd8, 1, 3000, -1, -1);
        chk("t9_cnt", query_cnt, 8'd255);
        chk("t9_imar", IMAR, 13'h402);
        chk("t9_starts_left", exp_q.size(), 0);

        // Reset during RUN, then a fresh batch.
        load(13'hA0, 8'd1, 8'd2, 8'hFF, 8'h00, 8'h00);
        exp_q.push_back({8'd1, 8'd2});
        eng_lat = 0;
        @(posedge clock); #1;
        host_start = 1'b1; base_addr = 13'hA0; num_nodes = 8'd8;
        plan(cyc, 13'hA0, 8'd8, 0);
        @(posedge clock); #1;
        host_start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset(cyc);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t10_state", state_dbg, S_IDLE);
        chk("t10_busy", busy, 1'b0);
        chk("t10_src", bf_src, 8'd0);
        chk("t10_imar", IMAR, 0);
        exp_q.push_back({8'd3, 8'd7});
        exp_q.push_back({8'd5, 8'd2});
        run_batch(13'h10, 8'd8, 20, 300, -1, -1);
        chk("t10_cnt", query_cnt, 8'd2);
        chk("t10_starts_left", exp_q.size(), 0);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
